bp_perf_counter: RTL
====================

# bp_perf_counter

Branch-prediction performance monitor that sits directly downstream of the predictor-variant core wrapper. It consumes the per-cycle branch-instruction, branch-miss and fetched-instruction observation signals. It accumulates cycle, instruction, branch and misprediction counts. On request it snapshots all four counts and streams them out over a valid/ready port for the bench or debug logger. It is identical for every predictor variant (always-taken, two-bit, gshare, agree).

## Interface
- CNT_W, 32, width of every counter and of rd_data_o (min 4)
- clk_i  in  1  clock, all state updates on rising edge
- rst_ni  in  1  reset, synchronous, active-low
- en_i  in  1  counting enable; no counter changes while low
- br_instr_i  in  1  branch/jump resolved this cycle
- br_miss_i  in  1  misprediction flush this cycle; counted independently of br_instr_i
- instr_i  in  32  instruction in fetch stage this cycle
- clr_i  in  1  zero all live counters and overflow flags
- snap_req_i  in  1  request snapshot + readout; honoured only in IDLE
- rd_valid_o  out  1  readout word valid
- rd_ready_i  in  1  consumer accepts word
- rd_data_o  out  CNT_W  snapshot word
- rd_idx_o  out  2  word index: 0 cycles, 1 instrs, 2 branches, 3 misses
- rd_last_o  out  1  high with rd_idx_o==3
- busy_o  out  1  high in SEND
- ovf_o  out  4  sticky per-counter overflow, bit order = rd_idx

## Operation
- Live counters (all CNT_W): cyc, ins, br, mis. Each cycle with en_i=1:
  - cyc += 1.
  - ins += 1 if instr_i ∉ {32'h0000_0013, 32'h0000_0000}. Bubbles and flush NOPs are not counted.
  - br += br_instr_i.
  - mis += br_miss_i.
- Overflow: an increment from all-ones sets the matching ovf_o bit (sticky). The counter result depends on the build configuration.
- clr_i=1: all live counters and ovf_o become 0 at the next edge. clr_i wins over any same-cycle increment. clr_i does not affect the shadow registers or an in-progress readout.
- FSM states: IDLE, SEND.
  - IDLE → SEND when snap_req_i=1. On that edge the shadow regs load the pre-update live values, so events of the capture cycle go only to the live counters. idx is set to 0.
  - SEND: rd_valid_o=1, rd_data_o=shadow[idx], rd_last_o=(idx==3).
  - Transfer occurs when rd_valid_o && rd_ready_i. A transfer with idx<3 increments idx. A transfer with idx==3 returns to IDLE.
- snap_req_i in SEND is ignored, not queued.
- snap_req_i with clr_i in the same cycle: the snapshot holds the pre-clear values, and the live counters clear.
- Live counting continues during SEND.

## Timing
- Reset (rst_ni=0 at an edge): state IDLE, all counters/shadows/idx 0. All outputs 0: rd_valid_o, rd_data_o, rd_idx_o, rd_last_o, busy_o, ovf_o.
- Reset mid-SEND aborts the stream; rd_valid_o is 0 the cycle after the reset edge.
- Latency: rd_valid_o and busy_o rise the cycle after the snap_req_i edge. At full throughput, 4 words take 4 consecutive cycles.
- While rd_valid_o && !rd_ready_i, rd_data_o, rd_idx_o and rd_last_o are held stable.
- rd_valid_o is never deasserted without a transfer, except on reset.
- After the idx-3 transfer, rd_valid_o and busy_o are 0 the next cycle. A snap_req_i in the last-transfer cycle is ignored; a new request is accepted from the following cycle.
- Counter update latency: 1 cycle, registered. ovf_o updates on the same edge as the wrapping increment.

## Configuration
- BP_PERF_SATURATE_EN defined: a counter at all-ones holds at all-ones on further increments. ovf_o is still set.
- Undefined (default): counters wrap modulo 2^CNT_W. ovf_o is set on the wrap.

## Test plan
- Reset: hold rst_ni=0 for 2 cycles with random inputs → all outputs 0, busy_o=0.
- Counting: en_i=1 for 10 cycles, 3 cycles of instr_i=32'h0000_0013, br_instr_i high 4 cycles, br_miss_i high 3 cycles (2 overlapping with br_instr_i), then snap_req_i with rd_ready_i=1 → words 10, 7, 4, 3 on idx 0..3 in consecutive cycles. rd_last_o is high only with idx 3.
- Backpressure: rd_ready_i=0 for 3 cycles while idx=1 → rd_data_o/rd_idx_o stable. Then rd_ready_i=1 → idx 2 and 3 follow, with no word lost or duplicated.
- Clear priority: clr_i and br_instr_i high with br=5 in the same cycle → br=0 next cycle. snap_req_i and clr_i in the same cycle → snapshot br=5, live br=0.
- Overflow with CNT_W=4: 17 enabled cycles → cyc=1 and ovf_o[0]=1 by default. With BP_PERF_SATURATE_EN, cyc=15 and ovf_o[0]=1.
- Abort/ignore: snap_req_i at idx 2 → ignored. rst_ni=0 at idx 2 → rd_valid_o=0 next cycle, counters 0.

Source files
------------

// File: rtl/bp_perf_counter.sv
// Branch-prediction performance monitor: live cycle/instr/branch/miss counters with snapshot
// readout over a valid/ready stream. Define BP_PERF_SATURATE_EN to saturate instead of wrap.
module bp_perf_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             br_instr_i,
  input  logic             br_miss_i,
  input  logic [31:0]      instr_i,
  input  logic             clr_i,
  input  logic             snap_req_i,
  output logic             rd_valid_o,
  input  logic             rd_ready_i,
  output logic [CNT_W-1:0] rd_data_o,
  output logic [1:0]       rd_idx_o,
  output logic             rd_last_o,
  output logic             busy_o,
  output logic [3:0]       ovf_o
);

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  state_e           state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q    [4];
  logic [CNT_W-1:0] cnt_d    [4];
  logic [CNT_W-1:0] shadow_q [4];
  logic [3:0]       ovf_q, ovf_d;
  logic [3:0]       inc;
  logic             load_shadow;
  logic             real_instr;

  // Canonical NOP (addi x0,x0,0) and all-zero bubbles are not real instructions.
  assign real_instr = (instr_i != 32'h0000_0013) && (instr_i != 32'h0000_0000);

  // Bit order matches rd_idx: cycles, instrs, branches, misses.
  assign inc = {en_i & br_miss_i, en_i & br_instr_i, en_i & real_instr, en_i};

  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    for (int i = 0; i < 4; i++) begin
      if (inc[i]) begin
        if (&cnt_q[i]) begin
          ovf_d[i] = 1'b1;
`ifdef BP_PERF_SATURATE_EN
          cnt_d[i] = cnt_q[i];
`else
          cnt_d[i] = '0;
`endif
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
    if (clr_i) begin
      for (int i = 0; i < 4; i++) begin
        cnt_d[i] = '0;
      end
      ovf_d = '0;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    load_shadow = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (snap_req_i) begin
          state_d     = StSend;
          idx_d       = 2'd0;
          load_shadow = 1'b1;
        end
      end
      StSend: begin
        if (rd_ready_i) begin
          if (idx_q == 2'd3) begin
            state_d = StIdle;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      idx_q   <= 2'd0;
      ovf_q   <= '0;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i]    <= '0;
        shadow_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
      // Shadow takes pre-update values so capture-cycle events land only in live counters.
      if (load_shadow) begin
        shadow_q <= cnt_q;
      end
    end
  end

  assign rd_valid_o = (state_q == StSend);
  assign busy_o     = rd_valid_o;
  assign rd_idx_o   = idx_q;
  assign rd_last_o  = rd_valid_o && (idx_q == 2'd3);
  assign rd_data_o  = rd_valid_o ? shadow_q[idx_q] : '0;
  assign ovf_o      = ovf_q;

endmodule
